// File: rtl/round_robin_dispatcher.sv
// round_robin_dispatcher: hands each beat of one valid/ready stream to one of N channels in round-robin order
module round_robin_dispatcher #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [W-1:0]         in_data,
   output logic                 in_ready,
   output logic [N-1:0]         out_valid,
   output logic [W-1:0]         out_data,
   input  logic [N-1:0]         out_ready,
   output logic [$clog2(N)-1:0] ptr,
   output logic                 busy
);
   localparam int IW = $clog2(N);
   logic          hold_valid;
   logic [W-1:0]  hold_data;
   logic [IW-1:0] hold_idx;
   logic          dep;
   logic          acc;
   logic [IW-1:0] nxt_idx;
   logic [IW-1:0] base;
   logic [IW-1:0] target;
   // handshake decode, output view of the hold register and circular search for the next free channel
   always_comb begin
      dep = hold_valid & out_ready[hold_idx];
      in_ready = ~rst & (~hold_valid | dep);
      acc = in_valid & in_ready;
      nxt_idx = (hold_idx == IW'(N - 1)) ? '0 : hold_idx + 1'b1;
      base = dep ? nxt_idx : ptr;
      target = base;
      for (int k = N - 1; k >= 0; k--) begin
         int j;
         j = int'(base) + k;
         if (j >= N) j -= N;
         if (out_ready[j]) target = IW'(j);
      end
      out_valid = hold_valid ? (N'(1) << hold_idx) : '0;
      out_data = hold_data;
      busy = hold_valid;
   end
   // hold register load/drain and round-robin pointer advance on each completed handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
         hold_idx   <= '0;
         ptr        <= '0;
      end else begin
         if (acc) begin
            hold_valid <= 1'b1;
            hold_data  <= in_data;
            hold_idx   <= target;
         end else if (dep) begin
            hold_valid <= 1'b0;
         end
         if (dep) ptr <= nxt_idx;
      end
   end
endmodule

// File: tb/tb_round_robin_dispatcher.sv
// tb_round_robin_dispatcher: scoreboard bench for the round-robin dispatcher
module tb_round_robin_dispatcher;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [3:0] out_valid;
   logic [7:0] out_data;
   logic [3:0] out_ready;
   logic [1:0] ptr;
   logic       busy;
   int         n_chk = 0;
   int         n_err = 0;
   logic [11:0] sb[$];

   round_robin_dispatcher #(.N(4), .W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .ptr(ptr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int ch, input logic [7:0] d);
      logic [3:0] oh;
      oh = 4'b0001 << ch;
      sb.push_back({oh, d});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // every completed handshake must match the oldest expected beat
   always @(negedge clk) begin
      if (!rst && |(out_valid & out_ready)) begin
         chk("onehot", 32'($onehot0(out_valid)), 32'd1);
         if (sb.size() == 0) chk("sb_extra", {out_valid, out_data}, 32'hfff);
         else chk("sb_beat", {20'd0, out_valid, out_data}, {20'd0, sb.pop_front()});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 4'b0000;
      step();
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ptr", ptr, 0);
      chk("rst_busy", busy, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      step();
      // T2: all ready, back-to-back
      out_ready = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data = 8'hA0 + 8'(i);
         push(i % 4, in_data);
         @(negedge clk);
         chk("t2_in_ready", in_ready, 1);
         if (i > 0) chk("t2_latency", out_valid, 32'(4'b0001 << ((i - 1) % 4)));
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("t2_last", out_valid, 4'b1000);
      step();
      @(negedge clk);
      chk("t2_ptr", ptr, 0);
      chk("t2_idle", busy, 0);
      step();
      // T3: skip non-ready channels
      out_ready = 4'b1010;
      in_valid = 1'b1; in_data = 8'h11; push(1, 8'h11);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t3_ch1", out_valid, 4'b0010);
      step();
      @(negedge clk);
      chk("t3_ptr2", ptr, 2);
      step();
      in_valid = 1'b1; in_data = 8'h22; push(3, 8'h22);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t3_ch3", out_valid, 4'b1000);
      step();
      @(negedge clk);
      chk("t3_ptr0", ptr, 0);
      step();
      // T4: set ptr=2, then stall with nobody ready
      out_ready = 4'b0010;
      in_valid = 1'b1; in_data = 8'h05; push(1, 8'h05);
      step();
      in_valid = 1'b0;
      step();
      @(negedge clk);
      chk("t4_ptr2", ptr, 2);
      step();
      out_ready = 4'b0000;
      in_valid = 1'b1; in_data = 8'h33; push(2, 8'h33);
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) out_ready = 4'b0010;
         @(negedge clk);
         chk("t4_hold_valid", out_valid, 4'b0100);
         chk("t4_hold_data", out_data, 8'h33);
         chk("t4_in_ready", in_ready, 0);
         step();
      end
      out_ready = 4'b0100;
      step();
      @(negedge clk);
      chk("t4_ptr3", ptr, 3);
      chk("t4_busy", busy, 0);
      step();
      // T5: departure from channel 3 with a simultaneous new beat
      out_ready = 4'b0000;
      in_valid = 1'b1; in_data = 8'h44; push(3, 8'h44);
      step();
      in_data = 8'h55;
      @(negedge clk);
      chk("t5_stalled", in_ready, 0);
      step();
      out_ready = 4'b1111;
      push(0, 8'h55);
      @(negedge clk);
      chk("t5_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t5_nobubble", out_valid, 4'b0001);
      chk("t5_data", out_data, 8'h55);
      chk("t5_ptr0", ptr, 0);
      step();
      // T6: reset during a stall drops the held beat
      out_ready = 4'b0000;
      in_valid = 1'b1; in_data = 8'h66;
      step();
      in_valid = 1'b0;
      step();
      @(negedge clk);
      chk("t6_stall", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_in_ready", in_ready, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_out_valid", out_valid, 0);
      chk("t6_ptr", ptr, 0);
      chk("t6_busy", busy, 0);
      step();
      out_ready = 4'b1111;
      in_valid = 1'b1; in_data = 8'h77; push(0, 8'h77);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t6_ch0", out_valid, 4'b0001);
      step();
      step();
      chk("sb_empty", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
